// File: rtl/noc_packet_tx_if.sv
// noc_packet_tx_if -- bundle of the local-core message port, the router
// packet port and the status outputs of noc_packet_tx.
//   Core side  : in_valid, in_ready, in_dst, in_type, in_payload, in_eop
//   Router side: packet, packet_valid, packet_ready, ack
//   Status     : busy, drop_pulse, sent_count, drop_count
// Modport master is the transmitter's view (it originates packets);
// modport slave is the view of the environment around it (core + router).
interface noc_packet_tx_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_dst;
    logic [1:0]  in_type;
    logic [7:0]  in_payload;
    logic        in_eop;
    logic [13:0] packet;
    logic        packet_valid;
    logic        packet_ready;
    logic        ack;
    logic        busy;
    logic        drop_pulse;
    logic [7:0]  sent_count;
    logic [7:0]  drop_count;

    modport master (
        input  in_valid, in_dst, in_type, in_payload, in_eop, packet_ready, ack,
        output in_ready, packet, packet_valid, busy, drop_pulse, sent_count, drop_count
    );

    modport slave (
        output in_valid, in_dst, in_type, in_payload, in_eop, packet_ready, ack,
        input  in_ready, packet, packet_valid, busy, drop_pulse, sent_count, drop_count
    );
endinterface

// File: rtl/noc_packet_tx.sv
// noc_packet_tx -- transmit side of the 14-bit NoC link.
// Messages from the local core are queued in a small FIFO, framed into a
// 14-bit packet {parity, dst, type, payload, eop} and offered to the router
// with valid/ready. After each transfer the block waits for an ack; on
// timeout it retransmits the held packet up to MAX_RETRY times, then drops it.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - noc_packet_tx_if.master (core port, router port, status/counters)
module noc_packet_tx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clk,
    input  logic               rst,
    noc_packet_tx_if.master    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

    state_t          state_q, state_d;
    logic [12:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            fifo_full, fifo_empty, push, pop;
    logic [12:0]     head;

    logic [13:0]     packet_q, packet_d;
    logic            packet_valid_q, packet_valid_d;
    logic            drop_pulse_q, drop_pulse_d;
    logic [7:0]      sent_q, sent_d;
    logic [7:0]      drop_q, drop_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retry_q, retry_d;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.in_valid && !fifo_full;
    // The FSM only takes a new entry while idle; the entry then lives in
    // packet_q until it is acked or dropped.
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q];

    assign bus.in_ready     = !fifo_full;
    assign bus.busy         = !fifo_empty || (state_q != IDLE);
    assign bus.packet       = packet_q;
    assign bus.packet_valid = packet_valid_q;
    assign bus.drop_pulse   = drop_pulse_q;
    assign bus.sent_count   = sent_q;
    assign bus.drop_count   = drop_q;

    // Storage array carries no reset so it can map onto distributed/block RAM;
    // stale contents are never visible because count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_dst, bus.in_type, bus.in_payload, bus.in_eop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            packet_q       <= '0;
            packet_valid_q <= 1'b0;
            drop_pulse_q   <= 1'b0;
            sent_q         <= '0;
            drop_q         <= '0;
            timer_q        <= '0;
            retry_q        <= '0;
        end else begin
            state_q        <= state_d;
            packet_q       <= packet_d;
            packet_valid_q <= packet_valid_d;
            drop_pulse_q   <= drop_pulse_d;
            sent_q         <= sent_d;
            drop_q         <= drop_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        packet_d       = packet_q;
        packet_valid_d = packet_valid_q;
        drop_pulse_d   = 1'b0;
        sent_d         = sent_q;
        drop_d         = drop_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    // Parity in bit 13 makes the total number of ones even.
                    packet_d       = {^head, head};
                    retry_d        = '0;
                    packet_valid_d = 1'b1;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (bus.packet_ready) begin
                    packet_valid_d = 1'b0;
                    timer_d        = '0;
                    state_d        = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Ack wins over a timeout firing on the same edge.
                if (bus.ack) begin
                    if (sent_q != 8'hFF) sent_d = sent_q + 8'd1;
                    state_d = IDLE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d        = retry_q + RW'(1);
                        packet_valid_d = 1'b1;
                        state_d        = SEND;
                    end else begin
                        drop_pulse_d = 1'b1;
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_noc_packet_tx.sv
// tb_noc_packet_tx -- directed bench for noc_packet_tx. Expected packets are
// pushed to a scoreboard queue when a message is accepted and compared by a
// monitor on every transfer (retransmissions are compared against the packet
// currently outstanding).
module tb_noc_packet_tx;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [13:0] exp_q[$];
    logic [13:0] cur_exp = '0;
    int          xfer_edge[$];
    bit          outstanding = 1'b0;

    noc_packet_tx_if bus ();

    noc_packet_tx #(
        .FIFO_DEPTH (4),
        .ACK_TIMEOUT(8),
        .MAX_RETRY  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [13:0] frame(input logic [1:0] d, input logic [1:0] t,
                                          input logic [7:0] p, input logic e);
        logic [12:0] b;
        b = {d, t, p, e};
        return {^b, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_msg(input logic [1:0] d, input logic [1:0] t,
                            input logic [7:0] p, input logic e);
        int n = 0;
        bus.in_dst = d; bus.in_type = t; bus.in_payload = p; bus.in_eop = e;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", 32'(bus.in_ready), 32'(1));
        exp_q.push_back(frame(d, t, p, e));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_xfer(input int budget);
        int x0 = xfer_edge.size();
        int n = 0;
        while (xfer_edge.size() == x0 && n < budget) begin
            tick();
            n++;
        end
        check("xfer_wait", 32'(xfer_edge.size() != x0), 32'(1));
    endtask

    // Monitor: at the falling edge, valid && ready means a transfer on the
    // next rising edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (bus.packet_valid && bus.packet_ready) begin
                if (!outstanding) begin
                    check("sb_unexpected", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
                    outstanding = 1'b1;
                end
                check("sb_packet", 32'(bus.packet), 32'(cur_exp));
                $display("xfer edge %0d packet %h", cyc + 1, bus.packet);
                xfer_edge.push_back(cyc + 1);
            end
            if (bus.ack || bus.drop_pulse) outstanding = 1'b0;
        end
    end

    initial begin
        int x0;
        int t0;
        int n;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_dst = '0; bus.in_type = '0;
        bus.in_payload = '0; bus.in_eop = 1'b0;
        bus.packet_ready = 1'b0; bus.ack = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_packet", 32'(bus.packet), 32'(0));
        check("rst_valid", 32'(bus.packet_valid), 32'(0));
        check("rst_drop_pulse", 32'(bus.drop_pulse), 32'(0));
        check("rst_sent", 32'(bus.sent_count), 32'(0));
        check("rst_drop", 32'(bus.drop_count), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        rst = 1'b0;
        tick();

        // Single send; parity bit is 1 because [12:0] holds seven ones
        bus.packet_ready = 1'b1;
        push_msg(2'd2, 2'd1, 8'hA5, 1'b1);
        check("s1_busy", 32'(bus.busy), 32'(1));
        check("s1_valid_early", 32'(bus.packet_valid), 32'(0));
        tick();
        check("s1_valid", 32'(bus.packet_valid), 32'(1));
        check("s1_packet", 32'(bus.packet), 32'(14'b1_10_01_10100101_1));
        tick();
        check("s1_valid_off", 32'(bus.packet_valid), 32'(0));
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("s1_sent", 32'(bus.sent_count), 32'(1));
        check("s1_busy_end", 32'(bus.busy), 32'(0));
        $display("single send done sent=%0d", bus.sent_count);

        // Backpressure
        bus.packet_ready = 1'b0;
        x0 = xfer_edge.size();
        push_msg(2'd0, 2'd3, 8'h3C, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.packet_valid), 32'(1));
            check("bp_packet", 32'(bus.packet), 32'(frame(2'd0, 2'd3, 8'h3C, 1'b0)));
            tick();
        end
        bus.packet_ready = 1'b1;
        tick();
        check("bp_valid_off", 32'(bus.packet_valid), 32'(0));
        check("bp_one_xfer", 32'(xfer_edge.size() - x0), 32'(1));
        repeat (3) tick();
        check("bp_still_one", 32'(xfer_edge.size() - x0), 32'(1));
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("bp_sent", 32'(bus.sent_count), 32'(2));
        $display("backpressure done sent=%0d", bus.sent_count);

        // Timeout, retries, drop
        x0 = xfer_edge.size();
        push_msg(2'd1, 2'd2, 8'h5A, 1'b1);
        n = 0;
        while (!bus.drop_pulse && n < 100) begin
            tick();
            n++;
        end
        check("to_drop_seen", 32'(bus.drop_pulse), 32'(1));
        check("to_xfers", 32'(xfer_edge.size() - x0), 32'(4));
        if (xfer_edge.size() >= x0 + 4) begin
            for (int k = 1; k < 4; k++)
                check("to_spacing", 32'(xfer_edge[x0+k] - xfer_edge[x0+k-1]), 32'(9));
            check("to_drop_edge", 32'(cyc - xfer_edge[x0+3]), 32'(8));
        end
        check("to_drop_count", 32'(bus.drop_count), 32'(1));
        check("to_sent", 32'(bus.sent_count), 32'(2));
        tick();
        check("to_pulse_width", 32'(bus.drop_pulse), 32'(0));
        check("to_busy", 32'(bus.busy), 32'(0));
        $display("timeout done drop=%0d", bus.drop_count);

        // Ack on the timeout edge
        push_msg(2'd3, 2'd0, 8'hC3, 1'b0);
        wait_xfer(20);
        t0 = (xfer_edge.size() != 0) ? xfer_edge[xfer_edge.size()-1] : cyc;
        n = 0;
        while (cyc < t0 + 7 && n < 20) begin
            tick();
            n++;
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("ate_sent", 32'(bus.sent_count), 32'(3));
        check("ate_drop", 32'(bus.drop_count), 32'(1));
        check("ate_valid", 32'(bus.packet_valid), 32'(0));
        x0 = xfer_edge.size();
        repeat (12) tick();
        check("ate_no_retx", 32'(xfer_edge.size() - x0), 32'(0));
        check("ate_busy", 32'(bus.busy), 32'(0));
        $display("ack on timeout edge done sent=%0d", bus.sent_count);

        // FIFO full and ordering
        bus.packet_ready = 1'b0;
        for (int p = 1; p <= 5; p++) push_msg(2'd1, 2'd1, 8'(p), 1'b1);
        check("ff_in_ready", 32'(bus.in_ready), 32'(0));
        bus.in_payload = 8'h06; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ff_stalled", 32'(bus.in_ready), 32'(0));
        end
        bus.in_valid = 1'b0;
        x0 = xfer_edge.size();
        bus.packet_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_xfer(20);
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
        end
        if (xfer_edge.size() >= x0 + 5) begin
            for (int k = 1; k < 5; k++)
                check("ff_spacing", 32'(xfer_edge[x0+k] - xfer_edge[x0+k-1]), 32'(3));
        end
        tick();
        check("ff_sent", 32'(bus.sent_count), 32'(8));
        check("ff_sb_empty", 32'(exp_q.size()), 32'(0));
        check("ff_busy", 32'(bus.busy), 32'(0));
        $display("fifo full/order done sent=%0d", bus.sent_count);

        // Reset mid-retry with two entries queued
        push_msg(2'd0, 2'd1, 8'h11, 1'b0);
        push_msg(2'd1, 2'd0, 8'h22, 1'b1);
        push_msg(2'd2, 2'd2, 8'h33, 1'b0);
        tick();
        check("mr_busy", 32'(bus.busy), 32'(1));
        check("mr_waiting", 32'(bus.packet_valid), 32'(0));
        rst = 1'b1;
        #1;
        check("mr_packet", 32'(bus.packet), 32'(0));
        check("mr_valid", 32'(bus.packet_valid), 32'(0));
        check("mr_sent", 32'(bus.sent_count), 32'(0));
        check("mr_drop", 32'(bus.drop_count), 32'(0));
        check("mr_busy_rst", 32'(bus.busy), 32'(0));
        check("mr_in_ready", 32'(bus.in_ready), 32'(1));
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        x0 = xfer_edge.size();
        repeat (20) tick();
        check("mr_no_xfer", 32'(xfer_edge.size() - x0), 32'(0));
        check("mr_valid_after", 32'(bus.packet_valid), 32'(0));
        check("mr_drop_after", 32'(bus.drop_count), 32'(0));
        check("mr_busy_after", 32'(bus.busy), 32'(0));
        $display("reset mid-retry done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
